// File: rtl/dff_reg_write_arbiter.sv
// Round-robin write arbiter for one shared W-bit register (IDLE -> WRITE -> ACK).
// Define DFF_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module dff_reg_write_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [W-1:0]   q,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_ACK} state_t;

  state_t          r_state, w_state_next;
  logic [W-1:0]    r_q, w_q_next;
  logic [N-1:0]    r_gnt, w_gnt_next;
  logic [N-1:0]    r_ack, w_ack_next;
  logic            r_busy, w_busy_next;
  logic [PW-1:0]   r_idx, w_idx_next;
  logic [PW-1:0]   w_win;
  logic            w_any;
  logic [W-1:0]    w_words [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_words
      assign w_words[gi] = wdata[gi*W +: W];
    end
  endgenerate

  assign w_any = |req;

`ifdef DFF_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest-index set bit is the last (winning) assignment.
  always_comb begin
    w_win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) w_win = PW'(k);
    end
  end
`else
  logic [PW-1:0] r_ptr, w_ptr_next;
  logic [PW-1:0] w_cand;
  logic          w_found;

  // Circular search starting at the pointer; first hit wins.
  always_comb begin
    w_win   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % N);
      if (!w_found && req[w_cand]) begin
        w_win   = w_cand;
        w_found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_gnt_next   = r_gnt;
    w_ack_next   = r_ack;
    w_busy_next  = r_busy;
    w_idx_next   = r_idx;
`ifndef DFF_ARB_FIXED_PRIO_EN
    w_ptr_next   = r_ptr;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_idx_next   = w_win;
          w_gnt_next   = N'(1) << w_win;
          w_busy_next  = 1'b1;
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_q_next     = w_words[r_idx];
        w_ack_next   = N'(1) << r_idx;
        w_state_next = S_ACK;
      end
      S_ACK: begin
        w_ack_next   = '0;
        w_gnt_next   = '0;
        w_busy_next  = 1'b0;
`ifndef DFF_ARB_FIXED_PRIO_EN
        w_ptr_next   = (r_idx == PW'(N - 1)) ? '0 : r_idx + 1'b1;
`endif
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_busy  <= 1'b0;
      r_idx   <= '0;
`ifndef DFF_ARB_FIXED_PRIO_EN
      r_ptr   <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_gnt   <= w_gnt_next;
      r_ack   <= w_ack_next;
      r_busy  <= w_busy_next;
      r_idx   <= w_idx_next;
`ifndef DFF_ARB_FIXED_PRIO_EN
      r_ptr   <= w_ptr_next;
`endif
    end
  end

  assign q    = r_q;
  assign gnt  = r_gnt;
  assign ack  = r_ack;
  assign busy = r_busy;

endmodule

// File: tb/tb_dff_reg_write_arbiter.sv
// Directed bench for dff_reg_write_arbiter (N=4, W=8); outputs sampled on the falling edge.
module tb_dff_reg_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [7:0]  q;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        busy;

  int n_checks;
  int n_pass;

  dff_reg_write_arbiter #(.N(4), .W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .q     (q),
    .gnt   (gnt),
    .ack   (ack),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction from IDLE with req already driven; wd is applied after the
  // grant so the write must pick up data present at the WRITE edge.
  task automatic serve(input string tag, input logic [3:0] exp_gnt,
                       input logic [31:0] wd, input logic [7:0] exp_q);
    tick();
    check({tag, ".gnt0"},  32'(gnt),  32'(exp_gnt));
    check({tag, ".ack0"},  32'(ack),  32'h0);
    check({tag, ".busy0"}, 32'(busy), 32'h1);
    wdata = wd;
    tick();
    check({tag, ".gnt1"},  32'(gnt),  32'(exp_gnt));
    check({tag, ".ack1"},  32'(ack),  32'(exp_gnt));
    check({tag, ".q1"},    32'(q),    32'(exp_q));
    tick();
    check({tag, ".gnt2"},  32'(gnt),  32'h0);
    check({tag, ".ack2"},  32'(ack),  32'h0);
    check({tag, ".busy2"}, 32'(busy), 32'h0);
    check({tag, ".q2"},    32'(q),    32'(exp_q));
    $display("txn %s: gnt=%b ack_seen q=%h", tag, exp_gnt, q);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst   = 1'b0;
    req   = 4'b1111;
    wdata = 32'h13121110;

    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst.outs", {20'h0, q, gnt, ack}, 32'h0);
      check("rst.busy", 32'(busy), 32'h0);
    end
    $display("txn reset: q=%h gnt=%b ack=%b busy=%b", q, gnt, ack, busy);
    rst = 1'b1;

`ifndef DFF_ARB_FIXED_PRIO_EN
    serve("rr0", 4'b0001, 32'h13121110, 8'h10);
    serve("rr1", 4'b0010, 32'h13121110, 8'h11);
    serve("rr2", 4'b0100, 32'h13121110, 8'h12);
    serve("rr3", 4'b1000, 32'h13121110, 8'h13);
    serve("rr4", 4'b0001, 32'h13121110, 8'h10);
    req = 4'b0000;
    tick();
    check("idle.busy", 32'(busy), 32'h0);
    check("idle.q",    32'(q),    32'h10);

    req   = 4'b0100;
    wdata = 32'h00FF0000;
    serve("single", 4'b0100, 32'h00A50000, 8'hA5);

    req   = 4'b1001;
    wdata = 32'h13121110;
    serve("wrap3", 4'b1000, 32'h13121110, 8'h13);
    req = 4'b0001;
    serve("wrap0", 4'b0001, 32'h13121110, 8'h10);

    req = 4'b0011;
    serve("ptr1", 4'b0010, 32'h13121110, 8'h11);
`else
    req = 4'b1010;
    serve("fix0", 4'b0010, 32'h13121110, 8'h11);
    serve("fix1", 4'b0010, 32'h13121110, 8'h11);
    serve("fix2", 4'b0010, 32'h13121110, 8'h11);
    serve("fix3", 4'b0010, 32'h13121110, 8'h11);
`endif

    req   = 4'b0010;
    wdata = 32'h00005A00;
    tick();
    check("mid.gnt", 32'(gnt), 32'h2);
    rst = 1'b0;
    tick();
    check("mid.outs", {20'h0, q, gnt, ack}, 32'h0);
    check("mid.busy", 32'(busy), 32'h0);
    rst = 1'b1;
    req = 4'b0000;
    tick();
    check("mid.post", {20'h0, q, gnt, ack}, 32'h0);
    check("mid.busy2", 32'(busy), 32'h0);
    $display("txn midreset: q=%h ack=%b busy=%b", q, ack, busy);

    req   = 4'b1111;
    wdata = 32'h13121110;
    serve("postrst", 4'b0001, 32'h13121177, 8'h77);
    req = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dff_reg_write_arbiter.md
Name: dff_reg_write_arbiter

Overview:
Round-robin write arbiter for one shared W-bit register built from synchronous D flip-flops. N requesters compete for the register. The arbiter selects one requester, loads that requester's data into the register and returns a one-cycle acknowledge. It sits between producer blocks and the shared register. It owns the register's clock enable and data-select sequencing.

Parameters:
N, 4, number of requesters (N >= 1)
W, 8, width of the shared register and of each requester's data word

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-low
req  input  N  per-requester write request; hold high until the matching ack
wdata  input  N*W  packed write data; requester i occupies bits [i*W +: W]
q  output  W  shared register contents
gnt  output  N  one-hot grant; high during WRITE and ACK, zero otherwise
ack  output  N  one-hot, one-cycle pulse marking the cycle q first shows the granted data
busy  output  1  high while state is WRITE or ACK

Behaviour:
- Outputs and reset:
  - All outputs are registered.
  - With rst=0 at a rising edge: state=IDLE, q=0, gnt=0, ack=0, busy=0, priority pointer ptr=0.
  - Pointer width is max(1, clog2(N)).
- FSM states: IDLE, WRITE, ACK.
- IDLE:
  - If req==0, stay in IDLE; q holds.
  - Otherwise pick winner idx: the first set bit of req, searching circularly from ptr upward (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
  - At the edge: latch idx, gnt<=onehot(idx), busy<=1, go to WRITE.
- WRITE:
  - At the edge: q<=wdata[idx], ack<=onehot(idx), go to ACK.
  - wdata is sampled at this edge, not in IDLE.
  - Dropping req[idx] during WRITE does not abort the write.
- ACK:
  - q holds the new value and ack[idx]=1 in the same cycle.
  - At the edge: ack<=0, gnt<=0, busy<=0, ptr<=(idx+1) mod N, go to IDLE.
- Timing:
  - Request sampled at edge E0 → gnt visible after E0 → q and ack visible after E1 → idle after E2.
  - Throughput is one write per 3 cycles; the next arbitration edge is E3 at the earliest.
- Simultaneous and new requests:
  - Multiple requests: only the winner is served; the others wait.
  - Requests arriving during WRITE or ACK are not sampled until IDLE.
- Held requests: a requester that keeps req high after its ack is re-eligible. Because the pointer has moved past it, it has lowest priority.
- Wrap-around: when idx=N-1, ptr becomes 0. With N=1, ptr stays 0 and requester 0 is always granted.
- Reset mid-operation: rst=0 in WRITE or ACK returns to the reset state at that edge.
  - No ack is issued.
  - q=0, even if the WRITE edge coincides with the reset; reset wins.
- No requester ever sees two acks for one request.

Optional Feature:
Macro: DFF_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index set req bit always wins; ptr is neither updated nor used.
- Undefined: round-robin as above.
- Ports, timing and every other behaviour are identical in both builds.

Test Plan:
- Reset: rst=0 for 2 cycles, req=4'b1111 → q=0, gnt=0, ack=0, busy=0 throughout. First grant after release goes to requester 0.
- Single write: req=4'b0100, wdata[2]=8'hA5, all other words 8'h00 → gnt=4'b0100 for 2 cycles; q=8'hA5 and ack=4'b0100 in the 2nd cycle; busy=0 in the 3rd.
- Round-robin fairness: req=4'b1111 held continuously, wdata[i]=8'h10+i → acks in order 0001, 0010, 0100, 1000, 0001. q walks 10, 11, 12, 13, 10, with one ack every 3 cycles.
- Wrap: serve requester 2 (so ptr=3), then req=4'b1001 → requester 3 is granted first, then 0; ptr=1 afterwards.
- Reset mid-op: req=4'b0010, wdata[1]=8'h5A, rst=0 at the WRITE→ACK edge → q=0, ack never asserted, state IDLE, ptr=0.
- Fixed priority (DFF_ARB_FIXED_PRIO_EN defined): req=4'b1010 held for 4 writes → every ack is 4'b0010; requester 3 is never granted.
